// File: rtl/t_counter_pkg.sv
// rtl/t_counter_pkg.sv - shared state encodings and direction constants for the toggle counter controller
package t_counter_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE = 2'd0;
   localparam state_t RUN  = 2'd1;
   localparam state_t HOLD = 2'd2;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/t_counter_ctrl_if.sv
// rtl/t_counter_ctrl_if.sv - command and status bundle between control logic and the counter controller
interface t_counter_ctrl_if #(
   parameter int WIDTH = 3
);
   logic             start;
   logic             stop;
   logic             pause;
   logic             dir;
   logic             periodic;
   logic [WIDTH-1:0] limit;
   logic             load_en;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             tc;
   logic             wrap;
   logic             done;
   logic             aborted;

   modport master (
      output start, stop, pause, dir, periodic, limit, load_en, load_val,
      input  count, busy, tc, wrap, done, aborted
   );

   modport slave (
      input  start, stop, pause, dir, periodic, limit, load_en, load_val,
      output count, busy, tc, wrap, done, aborted
   );
endinterface

// File: rtl/t_counter_ctrl_t_ff_cell.sv
// rtl/t_counter_ctrl_t_ff_cell.sv - single toggle flip-flop cell, the only storage for a count bit
module t_ff_cell (
   input  logic Clk,
   input  logic rst,
   input  logic T,
   output logic Q
);

   always_ff @(posedge Clk or negedge rst) begin
      if (!rst) begin
         Q <= 1'b0;
      end else if (T) begin
         Q <= ~Q;
      end
   end

endmodule

// File: rtl/t_counter_ctrl.sv
// rtl/t_counter_ctrl.sv - run/hold/idle sequencer driving a toggle-cell counter with terminal-count detection
module t_counter_ctrl #(
   parameter int WIDTH = 3
) (
   input  logic             Clk,
   input  logic             rst,
   t_counter_ctrl_if.slave  bus
);
   import t_counter_pkg::*;

   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0] ZERO = '0;

   state_t           state_q, state_d;
   logic             dir_q, per_q;
   logic [WIDTH-1:0] lim_q;
   logic             wrap_q, wrap_d;
   logic             done_q, done_d;
   logic             aborted_q, aborted_d;
   logic             capture;
   logic [WIDTH-1:0] count, nxt, tgl;
   logic [WIDTH-1:0] start_val, end_val;
   logic             tc;

   assign start_val = (dir_q == DIR_DOWN) ? lim_q : ZERO;
   assign end_val   = (dir_q == DIR_DOWN) ? ZERO  : lim_q;
   assign tc        = (state_q == RUN) && (count == end_val);

   always_comb begin
      state_d   = state_q;
      nxt       = count;
      wrap_d    = 1'b0;
      done_d    = 1'b0;
      aborted_d = 1'b0;
      capture   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               capture = 1'b1;
               nxt     = (bus.dir == DIR_DOWN) ? bus.limit : ZERO;
               state_d = RUN;
            end else if (bus.load_en) begin
               nxt = bus.load_val;
            end
         end
         RUN: begin
            if (bus.stop) begin
               state_d   = IDLE;
               aborted_d = 1'b1;
            end else if (tc) begin
               if (per_q) begin
                  nxt    = start_val;
                  wrap_d = 1'b1;
               end else begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end else if (bus.pause) begin
               state_d = HOLD;
            end else begin
               nxt = (dir_q == DIR_DOWN) ? count - ONE : count + ONE;
            end
         end
         HOLD: begin
            // Leaving HOLD deliberately takes no step on the resume edge.
            if (bus.stop) begin
               state_d   = IDLE;
               aborted_d = 1'b1;
            end else if (!bus.pause) begin
               state_d = RUN;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Bits change only where the next value differs, via their toggle cells.
   assign tgl = count ^ nxt;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      t_ff_cell u_cell (
         .Clk (Clk),
         .rst (rst),
         .T   (tgl[i]),
         .Q   (count[i])
      );
   end

   always_ff @(posedge Clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         dir_q     <= 1'b0;
         per_q     <= 1'b0;
         lim_q     <= '0;
         wrap_q    <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wrap_q    <= wrap_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
         if (capture) begin
            dir_q <= bus.dir;
            per_q <= bus.periodic;
            lim_q <= bus.limit;
         end
      end
   end

   assign bus.count   = count;
   assign bus.busy    = (state_q == RUN) || (state_q == HOLD);
   assign bus.tc      = tc;
   assign bus.wrap    = wrap_q;
   assign bus.done    = done_q;
   assign bus.aborted = aborted_q;

endmodule

// File: tb/tb_t_counter_ctrl.sv
// tb/tb_t_counter_ctrl.sv - directed-vector bench for the toggle counter controller
module tb_t_counter_ctrl;

   logic Clk = 1'b0;
   logic rst = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   t_counter_ctrl_if #(.WIDTH(3)) bus ();

   t_counter_ctrl #(.WIDTH(3)) dut (
      .Clk (Clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.start = 0; bus.stop = 0; bus.pause = 0; bus.dir = 0;
      bus.periodic = 0; bus.limit = 0; bus.load_en = 0; bus.load_val = 0;
   endtask

   task automatic launch(input logic d, input logic p, input logic [2:0] lim);
      bus.dir = d; bus.periodic = p; bus.limit = lim; bus.start = 1;
      tick();
      bus.start = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 0;
      #3;
      vectors++;
      if (bus.count !== 3'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
          bus.wrap !== 1'b0 || bus.aborted !== 1'b0) begin
         miscompares++;
         $display("FAIL reset: count=%0d busy=%b done=%b wrap=%b aborted=%b, required 0/0/0/0/0",
                  bus.count, bus.busy, bus.done, bus.wrap, bus.aborted);
      end
      tick();
      rst = 1;
      tick();
   endtask

   task automatic test_oneshot_up();
      launch(0, 0, 3'd5);
      vectors++;
      if (bus.count !== 3'd0 || bus.busy !== 1'b1) begin
         miscompares++;
         $display("FAIL up_start: count=%0d busy=%b, required 0/1", bus.count, bus.busy);
      end
      for (int i = 1; i <= 5; i++) begin
         tick();
         vectors++;
         if (bus.count !== 3'(i) || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL up_step%0d: count=%0d done=%b, required %0d/0", i, bus.count, bus.done, i);
         end
      end
      vectors++;
      if (bus.tc !== 1'b1) begin
         miscompares++;
         $display("FAIL up_tc: tc=%b, required 1", bus.tc);
      end
      tick();
      vectors++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.count !== 3'd5) begin
         miscompares++;
         $display("FAIL up_done: done=%b busy=%b count=%0d, required 1/0/5", bus.done, bus.busy, bus.count);
      end
      tick();
      vectors++;
      if (bus.done !== 1'b0 || bus.count !== 3'd5) begin
         miscompares++;
         $display("FAIL up_after: done=%b count=%0d, required 0/5", bus.done, bus.count);
      end
   endtask

   task automatic test_periodic_down();
      logic [2:0] exp_cnt  [5] = '{3'd2, 3'd1, 3'd0, 3'd3, 3'd2};
      logic       exp_wrap [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      launch(1, 1, 3'd3);
      bus.dir = 0; bus.periodic = 0; bus.limit = 3'd6;
      vectors++;
      if (bus.count !== 3'd3) begin
         miscompares++;
         $display("FAIL down_start: count=%0d, required 3", bus.count);
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         vectors++;
         if (bus.count !== exp_cnt[i] || bus.wrap !== exp_wrap[i] || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL down_step%0d: count=%0d wrap=%b done=%b, required %0d/%b/0",
                     i, bus.count, bus.wrap, bus.done, exp_cnt[i], exp_wrap[i]);
         end
      end
      bus.stop = 1;
      tick();
      bus.stop = 0;
      vectors++;
      if (bus.aborted !== 1'b1 || bus.busy !== 1'b0 || bus.count !== 3'd2) begin
         miscompares++;
         $display("FAIL down_stop: aborted=%b busy=%b count=%0d, required 1/0/2", bus.aborted, bus.busy, bus.count);
      end
   endtask

   task automatic test_pause();
      logic [2:0] exp_cnt [5] = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd3};
      launch(0, 0, 3'd6);
      tick();
      tick();
      bus.pause = 1;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (i == 2) bus.pause = 0;
         vectors++;
         if (bus.count !== exp_cnt[i] || bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL pause%0d: count=%0d busy=%b, required %0d/1", i, bus.count, bus.busy, exp_cnt[i]);
         end
      end
      bus.stop = 1;
      tick();
      bus.stop = 0;
      tick();
   endtask

   task automatic test_stop_at_tc();
      launch(0, 0, 3'd4);
      for (int i = 0; i < 4; i++) tick();
      bus.pause = 1;
      vectors++;
      if (bus.count !== 3'd4 || bus.tc !== 1'b1) begin
         miscompares++;
         $display("FAIL stop_tc_pre: count=%0d tc=%b, required 4/1", bus.count, bus.tc);
      end
      bus.stop = 1;
      tick();
      bus.stop = 0;
      bus.pause = 0;
      vectors++;
      if (bus.aborted !== 1'b1 || bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.count !== 3'd4) begin
         miscompares++;
         $display("FAIL stop_tc: aborted=%b done=%b busy=%b count=%0d, required 1/0/0/4",
                  bus.aborted, bus.done, bus.busy, bus.count);
      end
      tick();
      vectors++;
      if (bus.aborted !== 1'b0 || bus.done !== 1'b0) begin
         miscompares++;
         $display("FAIL stop_tc_after: aborted=%b done=%b, required 0/0", bus.aborted, bus.done);
      end
   endtask

   task automatic test_limits();
      launch(0, 0, 3'd0);
      vectors++;
      if (bus.count !== 3'd0 || bus.tc !== 1'b1 || bus.busy !== 1'b1) begin
         miscompares++;
         $display("FAIL lim0_run: count=%0d tc=%b busy=%b, required 0/1/1", bus.count, bus.tc, bus.busy);
      end
      tick();
      vectors++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL lim0_done: done=%b busy=%b, required 1/0", bus.done, bus.busy);
      end
      launch(0, 1, 3'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++;
         if (bus.count !== 3'd0 || bus.wrap !== 1'b1 || bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL lim0_per%0d: count=%0d wrap=%b busy=%b, required 0/1/1", i, bus.count, bus.wrap, bus.busy);
         end
      end
      bus.stop = 1;
      tick();
      bus.stop = 0;
      launch(0, 0, 3'd7);
      for (int i = 1; i <= 7; i++) begin
         tick();
         vectors++;
         if (bus.count !== 3'(i)) begin
            miscompares++;
            $display("FAIL lim7_step%0d: count=%0d, required %0d", i, bus.count, i);
         end
      end
      tick();
      vectors++;
      if (bus.done !== 1'b1 || bus.count !== 3'd7 || bus.wrap !== 1'b0 || bus.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL lim7_done: done=%b count=%0d wrap=%b busy=%b, required 1/7/0/0",
                  bus.done, bus.count, bus.wrap, bus.busy);
      end
   endtask

   task automatic test_load_and_reset();
      bus.load_en = 1; bus.load_val = 3'd6;
      tick();
      bus.load_en = 0;
      vectors++;
      if (bus.count !== 3'd6 || bus.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL load: count=%0d busy=%b, required 6/0", bus.count, bus.busy);
      end
      launch(0, 0, 3'd5);
      tick();
      bus.start = 1; bus.limit = 3'd1; bus.load_en = 1; bus.load_val = 3'd6;
      tick();
      bus.start = 0; bus.load_en = 0;
      vectors++;
      if (bus.count !== 3'd2 || bus.busy !== 1'b1) begin
         miscompares++;
         $display("FAIL busy_ignore: count=%0d busy=%b, required 2/1", bus.count, bus.busy);
      end
      tick();
      rst = 0;
      #1;
      vectors++;
      if (bus.count !== 3'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.aborted !== 1'b0) begin
         miscompares++;
         $display("FAIL async_rst: count=%0d busy=%b done=%b aborted=%b, required 0/0/0/0",
                  bus.count, bus.busy, bus.done, bus.aborted);
      end
      tick();
      rst = 1;
   endtask

   initial begin
      test_reset();
      test_oneshot_up();
      test_periodic_down();
      test_pause();
      test_stop_at_tc();
      test_limits();
      test_load_and_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
